// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the load/store memory access controller: op codes,
// ls_control size codes and the controller state enumeration.
package mem_access_ctrl_pkg;

  localparam logic [2:0] OP_LB = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LW = 3'b010;
  localparam logic [2:0] OP_SB = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SW = 3'b110;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WB,
    ST_MERGE,
    ST_WRITE,
    ST_FIN,
    ST_ERR
  } state_e;

  // Size field lives in op[1:0] for both loads and stores; 11 is never legal.
  function automatic logic op_legal(input logic [1:0] size_bits);
    return size_bits != 2'b11;
  endfunction

  function automatic logic [1:0] op_size(input logic [1:0] size_bits);
    case (size_bits)
      2'b00:   return LS_BYTE;
      2'b01:   return LS_HALF;
      default: return LS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_merge.sv
// Combinational lane logic: right-aligns the addressed byte/halfword of a read
// word for loads, and inserts store data into the addressed lane for SB/SH.
module lane_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] st_lo,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  always_comb begin
    ld_data = word;
    st_word = word;
    case (size)
      LS_BYTE: begin
        ld_data = word >> {addr_lo, 3'b000};
        st_word[{addr_lo, 3'b000} +: 8] = st_lo[7:0];
      end
      LS_HALF: begin
        // addr_lo[0] is deliberately ignored: a misaligned half uses lane addr[1]
        ld_data = word >> {addr_lo[1], 4'b0000};
        st_word[{addr_lo[1], 4'b0000} +: 16] = st_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller with per-phase mem_ready timeout.
// Define LSCTRL_ALIGN_CHECK_EN to reject misaligned LH/SH/LW/SW before any access.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mdr_data,
  output logic        mdr_load,
  output logic [1:0]  ls_control,
  output logic        reg_write,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       st_q, st_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        size_q;
  logic [31:0]       ld_word;
  logic [31:0]       merged_word;
  logic              align_bad;

  assign size_q = op_size(op_q[1:0]);

  lane_merge u_lane_merge (
    .word    (rdata_q),
    .st_lo   (st_q[15:0]),
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .ld_data (ld_word),
    .st_word (merged_word)
  );

`ifdef LSCTRL_ALIGN_CHECK_EN
  always_comb begin
    case (op[1:0])
      2'b01:   align_bad = addr[0];
      2'b10:   align_bad = (addr[1:0] != 2'b00);
      default: align_bad = 1'b0;
    endcase
  end
`else
  assign align_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      st_q    <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      st_q    <= st_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    st_d    = st_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          st_d   = st_data;
          cnt_d  = '0;
          if (!op_legal(op[1:0]) || align_bad) state_d = ST_ERR;
          else if (op == OP_SW)                state_d = ST_WRITE;
          else                                 state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = op_q[2] ? ST_MERGE : ST_CAPTURE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: state_d = ST_WB;
      ST_WB:      state_d = ST_IDLE;
      ST_MERGE: begin
        wdata_d = merged_word;
        cnt_d   = '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (mem_ready)              state_d = ST_FIN;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
        else                        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset clears them immediately.
  always_comb begin
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    mdr_data   = '0;
    mdr_load   = 1'b0;
    ls_control = LS_BYTE;
    reg_write  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_READ: mem_rd = 1'b1;
      ST_CAPTURE: begin
        mdr_load   = 1'b1;
        mdr_data   = ld_word;
        ls_control = size_q;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        mdr_data   = ld_word;
        ls_control = size_q;
      end
      ST_WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = (op_q == OP_SW) ? st_q : wdata_q;
      end
      ST_FIN: done = 1'b1;
      ST_ERR: begin
        err  = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
